// File: rtl/usb_bus_pkg.sv
// Shared encodings for the USB full-speed bus state controller:
// FSM state codes, decoded line-state codes and small helpers.
package usb_bus_pkg;

    localparam logic [2:0] ST_ATTACH_WAIT = 3'd0;
    localparam logic [2:0] ST_ACTIVE      = 3'd1;
    localparam logic [2:0] ST_BUS_RESET   = 3'd2;
    localparam logic [2:0] ST_SUSPENDED   = 3'd3;
    localparam logic [2:0] ST_REMOTE_WAKE = 3'd4;
    localparam logic [2:0] ST_RESUMING    = 3'd5;

    typedef enum logic [2:0] {
        S_ATTACH_WAIT = ST_ATTACH_WAIT,
        S_ACTIVE      = ST_ACTIVE,
        S_BUS_RESET   = ST_BUS_RESET,
        S_SUSPENDED   = ST_SUSPENDED,
        S_REMOTE_WAKE = ST_REMOTE_WAKE,
        S_RESUMING    = ST_RESUMING
    } bus_state_e;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    function automatic logic [1:0] line_decode(input logic p, input logic n);
        case ({p, n})
            2'b10:   return LINE_J;
            2'b01:   return LINE_K;
            2'b00:   return LINE_SE0;
            default: return LINE_SE1;
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchronizer for the raw D+/D- pins; the second stage
// holds the decoded line state (J, K, SE0, SE1).
module usb_line_sync
    import usb_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_usb_p,
    input  logic       i_usb_n,
    output logic [1:0] o_line
);

    logic [1:0] r_meta;
    logic [1:0] r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 2'b00;
            r_line <= LINE_SE0;
        end else begin
            r_meta <= {i_usb_p, i_usb_n};
            r_line <= line_decode(r_meta[1], r_meta[0]);
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/usb_bus_state_ctrl.sv
// USB full-speed device bus-state sequencer: attach delay, bus reset,
// suspend, host resume and remote wakeup, all timed from one run timer.
module usb_bus_state_ctrl
    import usb_bus_pkg::*;
#(
    parameter int unsigned ATTACH_CYCLES       = 48000,
    parameter int unsigned RESET_CYCLES        = 30000,
    parameter int unsigned SUSPEND_CYCLES      = 144000,
    parameter int unsigned RESUME_DET_CYCLES   = 48,
    parameter int unsigned WAKE_HOLDOFF_CYCLES = 240000,
    parameter int unsigned WAKE_DRIVE_CYCLES   = 96000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       wake_req,
    output logic       pullup_en,
    output logic       usb_reset,
    output logic       reset_done,
    output logic       suspended,
    output logic       drive_k,
    output logic [2:0] state
);

    localparam int unsigned MAX_CYC = max2(max2(max2(ATTACH_CYCLES, RESET_CYCLES),
                                                max2(SUSPEND_CYCLES, RESUME_DET_CYCLES)),
                                           max2(WAKE_HOLDOFF_CYCLES, WAKE_DRIVE_CYCLES));
    localparam int unsigned TW = $clog2(MAX_CYC + 1);

    logic [1:0]    w_line;
    logic [1:0]    r_line_prev;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_dwell;
    logic          r_se0_seen;
    bus_state_e    r_state;
    bus_state_e    w_next;
    logic          w_stable;
    logic          w_q_reset;
    logic          w_q_suspend;
    logic          w_q_resume;
    logic          w_line_chg;
    logic          r_pullup_en;
    logic          r_usb_reset;
    logic          r_reset_done;
    logic          r_suspended;
    logic          r_drive_k;

    usb_line_sync u_line_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_usb_p (usb_p_rx),
        .i_usb_n (usb_n_rx),
        .o_line  (w_line)
    );

    // A line event qualifies once the run timer reaches N-1 with the line unchanged.
    assign w_stable    = (w_line == r_line_prev);
    assign w_q_reset   = w_stable && (w_line == LINE_SE0) && (r_timer == TW'(RESET_CYCLES - 1));
    assign w_q_suspend = w_stable && (w_line == LINE_J)   && (r_timer == TW'(SUSPEND_CYCLES - 1));
    assign w_q_resume  = w_stable && (w_line == LINE_K)   && (r_timer == TW'(RESUME_DET_CYCLES - 1));

    // Attach and remote-wake timing run off the clock alone, not the line.
    assign w_line_chg  = !w_stable && (r_state != S_ATTACH_WAIT) && (r_state != S_REMOTE_WAKE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ATTACH_WAIT: if (r_timer == TW'(ATTACH_CYCLES - 1)) w_next = S_ACTIVE;
            S_ACTIVE: begin
                if (w_q_reset)        w_next = S_BUS_RESET;
                else if (w_q_suspend) w_next = S_SUSPENDED;
            end
            S_BUS_RESET:   if (w_line != LINE_SE0) w_next = S_ACTIVE;
            S_SUSPENDED: begin
                if (w_q_reset)        w_next = S_BUS_RESET;
                else if (w_q_resume)  w_next = S_RESUMING;
                else if (wake_req && (r_dwell >= TW'(WAKE_HOLDOFF_CYCLES)))
                                      w_next = S_REMOTE_WAKE;
            end
            S_REMOTE_WAKE: if (r_timer == TW'(WAKE_DRIVE_CYCLES - 1)) w_next = S_RESUMING;
            S_RESUMING: begin
                if (w_q_reset)                           w_next = S_BUS_RESET;
                else if (r_se0_seen && w_line == LINE_J) w_next = S_ACTIVE;
            end
            default:       w_next = S_ATTACH_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_ATTACH_WAIT;
            r_line_prev  <= LINE_SE0;
            r_timer      <= '0;
            r_dwell      <= '0;
            r_se0_seen   <= 1'b0;
            r_pullup_en  <= 1'b0;
            r_usb_reset  <= 1'b0;
            r_reset_done <= 1'b0;
            r_suspended  <= 1'b0;
            r_drive_k    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_line_prev <= w_line;

            if ((w_next != r_state) || w_line_chg) r_timer <= '0;
            else if (r_timer != {TW{1'b1}})        r_timer <= r_timer + TW'(1);

            if (w_next != r_state)                 r_dwell <= '0;
            else if (r_dwell != {TW{1'b1}})        r_dwell <= r_dwell + TW'(1);

            // End-of-resume needs SE0 seen while resuming before J returns.
            if (w_next != r_state)                                   r_se0_seen <= 1'b0;
            else if (r_state == S_RESUMING && w_line == LINE_SE0)    r_se0_seen <= 1'b1;

            r_pullup_en  <= (r_state != S_ATTACH_WAIT);
            r_usb_reset  <= (w_next == S_BUS_RESET);
            r_reset_done <= (r_state == S_BUS_RESET) && (w_next == S_ACTIVE);
            r_suspended  <= (w_next == S_SUSPENDED) || (w_next == S_REMOTE_WAKE) ||
                            (w_next == S_RESUMING);
            r_drive_k    <= (w_next == S_REMOTE_WAKE);
        end
    end

    assign pullup_en  = r_pullup_en;
    assign usb_reset  = r_usb_reset;
    assign reset_done = r_reset_done;
    assign suspended  = r_suspended;
    assign drive_k    = r_drive_k;
    assign state      = r_state;

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// Directed bench for usb_bus_state_ctrl with short timing parameters;
// expected cycle counts are hand-derived from sync + qualify + register latency.
module tb_usb_bus_state_ctrl;
    import usb_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       usb_p_rx;
    logic       usb_n_rx;
    logic       wake_req;
    logic       pullup_en;
    logic       usb_reset;
    logic       reset_done;
    logic       suspended;
    logic       drive_k;
    logic [2:0] state;

    int n_total = 0;
    int n_bad   = 0;

    usb_bus_state_ctrl #(
        .ATTACH_CYCLES       (10),
        .RESET_CYCLES        (20),
        .SUSPEND_CYCLES      (50),
        .RESUME_DET_CYCLES   (4),
        .WAKE_HOLDOFF_CYCLES (30),
        .WAKE_DRIVE_CYCLES   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .wake_req   (wake_req),
        .pullup_en  (pullup_en),
        .usb_reset  (usb_reset),
        .reset_done (reset_done),
        .suspended  (suspended),
        .drive_k    (drive_k),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input logic [1:0] code);
        {usb_p_rx, usb_n_rx} = code;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] tgt, input int max_cyc);
        int i = 0;
        while (state != tgt && i < max_cyc) begin
            tick(1);
            i++;
        end
        chk(tag, 32'(state), 32'(tgt));
    endtask

    initial begin
        logic seen_rst;
        int   n_k;

        rst_n    = 1'b0;
        wake_req = 1'b0;
        set_line(LINE_J);
        #12;
        chk("rst_state",   32'(state), 32'(ST_ATTACH_WAIT));
        chk("rst_pullup",  32'(pullup_en), 0);
        chk("rst_usbrst",  32'(usb_reset), 0);
        chk("rst_done",    32'(reset_done), 0);
        chk("rst_susp",    32'(suspended), 0);
        chk("rst_drivek",  32'(drive_k), 0);

        // Attach: ACTIVE at edge 10, pull-up at edge 11.
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(9);
        chk("attach_pullup_early", 32'(pullup_en), 0);
        tick(1);
        chk("attach_state", 32'(state), 32'(ST_ACTIVE));
        chk("attach_pullup_still0", 32'(pullup_en), 0);
        tick(1);
        chk("attach_pullup", 32'(pullup_en), 1);

        // 25-cycle SE0: usb_reset at +23, drops 3 cycles after J returns.
        set_line(LINE_SE0);
        tick(22);
        chk("busrst_early", 32'(usb_reset), 0);
        tick(1);
        chk("busrst_high", 32'(usb_reset), 1);
        chk("busrst_state", 32'(state), 32'(ST_BUS_RESET));
        tick(2);
        set_line(LINE_J);
        tick(2);
        chk("busrst_hold", 32'(usb_reset), 1);
        chk("busrst_done_early", 32'(reset_done), 0);
        tick(1);
        chk("busrst_low", 32'(usb_reset), 0);
        chk("busrst_done_pulse", 32'(reset_done), 1);
        chk("busrst_active", 32'(state), 32'(ST_ACTIVE));
        tick(1);
        chk("busrst_done_once", 32'(reset_done), 0);

        // 19-cycle SE0 must not qualify; then J idle reaches suspend at +53.
        seen_rst = 1'b0;
        set_line(LINE_SE0);
        for (int i = 0; i < 19; i++) begin
            tick(1);
            seen_rst |= usb_reset;
        end
        set_line(LINE_J);
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            seen_rst |= usb_reset;
            if (i == 52) chk("susp_early", 32'(suspended), 0);
            if (i == 53) begin
                chk("susp_high", 32'(suspended), 1);
                chk("susp_state", 32'(state), 32'(ST_SUSPENDED));
            end
        end
        chk("short_se0_no_reset", 32'(seen_rst), 0);

        // Host resume: K 6, SE0 2, J.
        set_line(LINE_K);
        tick(6);
        chk("resume_wait", 32'(state), 32'(ST_SUSPENDED));
        set_line(LINE_SE0);
        tick(1);
        chk("resume_state", 32'(state), 32'(ST_RESUMING));
        tick(1);
        set_line(LINE_J);
        tick(2);
        chk("resume_hold", 32'(state), 32'(ST_RESUMING));
        chk("resume_susp", 32'(suspended), 1);
        tick(1);
        chk("resume_active", 32'(state), 32'(ST_ACTIVE));
        chk("resume_unsusp", 32'(suspended), 0);

        // Remote wakeup: wake_req at dwell 10, K driven from dwell 31 for 15 cycles.
        tick(49);
        chk("wake_susp_early", 32'(suspended), 0);
        tick(1);
        chk("wake_susp", 32'(suspended), 1);
        tick(10);
        wake_req = 1'b1;
        tick(20);
        chk("wake_holdoff", 32'(drive_k), 0);
        chk("wake_holdoff_state", 32'(state), 32'(ST_SUSPENDED));
        tick(1);
        chk("wake_drivek", 32'(drive_k), 1);
        chk("wake_state", 32'(state), 32'(ST_REMOTE_WAKE));
        n_k = 1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            n_k += int'(drive_k);
        end
        chk("wake_k_len", 32'(n_k), 15);
        chk("wake_resuming", 32'(state), 32'(ST_RESUMING));
        chk("wake_k_off", 32'(drive_k), 0);
        chk("wake_still_susp", 32'(suspended), 1);
        wake_req = 1'b0;

        // Back to ACTIVE, into REMOTE_WAKE again, then async reset mid-wakeup.
        set_line(LINE_SE0);
        tick(3);
        set_line(LINE_J);
        wait_state("rw2_active", ST_ACTIVE, 10);
        wake_req = 1'b1;
        tick(3);
        chk("wake_ignored_active", 32'(state), 32'(ST_ACTIVE));
        wait_state("rw2_susp", ST_SUSPENDED, 70);
        wait_state("rw2_wake", ST_REMOTE_WAKE, 40);
        tick(5);
        chk("rw2_drivek", 32'(drive_k), 1);
        rst_n    = 1'b0;
        wake_req = 1'b0;
        #1;
        chk("arst_drivek", 32'(drive_k), 0);
        chk("arst_pullup", 32'(pullup_en), 0);
        chk("arst_susp",   32'(suspended), 0);
        chk("arst_state",  32'(state), 32'(ST_ATTACH_WAIT));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_state("reattach", ST_ACTIVE, 20);
        tick(1);
        chk("reattach_pullup", 32'(pullup_en), 1);

        // Bus reset and wake become eligible on the same cycle: reset wins.
        wait_state("prec_susp", ST_SUSPENDED, 70);
        tick(10);
        set_line(LINE_SE0);
        tick(22);
        chk("prec_pre", 32'(state), 32'(ST_SUSPENDED));
        wake_req = 1'b1;
        tick(1);
        chk("prec_state",  32'(state), 32'(ST_BUS_RESET));
        chk("prec_drivek", 32'(drive_k), 0);
        chk("prec_susp",   32'(suspended), 0);
        chk("prec_usbrst", 32'(usb_reset), 1);
        tick(3);
        chk("prec_drivek_later", 32'(drive_k), 0);
        wake_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
